// File: rtl/usr_shift_reg_if.sv
// Bus bundle for usr_shift_reg: mode/serial/parallel controls in, register view and FSM status out.
// The master side drives the controls; the slave side is the register itself.
interface usr_shift_reg_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       mode;
  logic             ser_in_r;
  logic             ser_in_l;
  logic [WIDTH-1:0] pdata;
  logic             start;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output mode, ser_in_r, ser_in_l, pdata, start,
    input  q, qbar, ser_out, busy, done
  );

  modport slave (
    input  mode, ser_in_r, ser_in_l, pdata, start,
    output q, qbar, ser_out, busy, done
  );
endinterface

// File: rtl/usr_shift_reg.sv
// Universal shift register (hold/right/left/load) with an auto-serialiser that shifts WIDTH times then pulses done; 1-edge latency, no backpressure.
// Defining USR_CLK_Q_DELAY_EN puts a #3 clock-to-q model on every output; left undefined the outputs are zero-delay.
module usr_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic            clock,
  input  logic            clear,
  usr_shift_reg_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // A one-bit register finishes on its first shift, so it skips SHIFT entirely.
  localparam state_e ST_AFTER_FIRST = (WIDTH > 1) ? ST_SHIFT : ST_DONE;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             dir_q, dir_d;   // 0 = right, 1 = left
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   right_ext;
  logic [WIDTH:0]   left_ext;
  logic [WIDTH-1:0] shr;
  logic [WIDTH-1:0] shl;

  logic [WIDTH-1:0] qbar_c;
  logic             ser_out_c;
  logic             busy_c;
  logic             done_c;

  // Widening by one bit keeps both shifts legal when WIDTH is 1.
  assign right_ext = {bus.ser_in_r, q_q};
  assign left_ext  = {q_q, bus.ser_in_l};
  assign shr       = right_ext[WIDTH:1];
  assign shl       = left_ext[WIDTH-1:0];

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        case (bus.mode)
          2'b01: begin
            q_d   = shr;
            dir_d = 1'b0;
          end
          2'b10: begin
            q_d   = shl;
            dir_d = 1'b1;
          end
          2'b11:   q_d = bus.pdata;
          default: q_d = q_q;
        endcase
        // The start edge itself is the first of the WIDTH auto shifts.
        if (bus.start && (bus.mode == 2'b01 || bus.mode == 2'b10)) begin
          cnt_d   = CNT_LAST;
          state_d = ST_AFTER_FIRST;
        end
      end
      ST_SHIFT: begin
        q_d   = dir_q ? shl : shr;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    qbar_c    = ~q_q;
    ser_out_c = dir_q ? q_q[WIDTH-1] : q_q[0];
    busy_c    = (state_q == ST_SHIFT);
    done_c    = (state_q == ST_DONE);
  end

`ifdef USR_CLK_Q_DELAY_EN
  assign #3 bus.q       = q_q;
  assign #3 bus.qbar    = qbar_c;
  assign #3 bus.ser_out = ser_out_c;
  assign #3 bus.busy    = busy_c;
  assign #3 bus.done    = done_c;
`else
  assign bus.q       = q_q;
  assign bus.qbar    = qbar_c;
  assign bus.ser_out = ser_out_c;
  assign bus.busy    = busy_c;
  assign bus.done    = done_c;
`endif

endmodule

// File: tb/tb_usr_shift_reg.sv
// Directed bench for usr_shift_reg (WIDTH=8): clear, load/shift, auto-serialise, abort and ignored-start cases.
// Outputs are sampled 6 ns after each rising edge so the delayed-output build behaves identically.
module tb_usr_shift_reg;

  logic clock;
  logic clear;
  int   n_cmp;
  int   n_err;

  usr_shift_reg_if #(.WIDTH(8)) bus ();

  usr_shift_reg #(.WIDTH(8)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #6;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] qe;
    logic [7:0] ser_exp;

    n_cmp = 0;
    n_err = 0;
    clear        = 1'b1;
    bus.mode     = 2'b00;
    bus.ser_in_r = 1'b0;
    bus.ser_in_l = 1'b0;
    bus.pdata    = 8'h00;
    bus.start    = 1'b0;
    #6;
    check("rst_q",    bus.q,    8'h00);
    check("rst_qbar", bus.qbar, 8'hFF);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    @(negedge clock);
    clear = 1'b0;
    tick();

    // Clear pulsed mid-cycle with q=3C
    bus.mode  = 2'b11;
    bus.pdata = 8'h3C;
    tick();
    check("load_3c", bus.q, 8'h3C);
    bus.mode = 2'b00;
    #2 clear = 1'b1;
    #4;
    check("clr_q",    bus.q,    8'h00);
    check("clr_qbar", bus.qbar, 8'hFF);
    check("clr_busy", bus.busy, 1'b0);
    check("clr_done", bus.done, 1'b0);
    clear = 1'b0;
    tick();
    check("hold_after_clr", bus.q, 8'h00);

    // Parallel load then shift right
    bus.mode  = 2'b11;
    bus.pdata = 8'hA5;
    tick();
    check("load_a5_q",    bus.q,    8'hA5);
    check("load_a5_qbar", bus.qbar, 8'h5A);
    bus.mode     = 2'b01;
    bus.ser_in_r = 1'b1;
    tick();
    check("shr_q",       bus.q,       8'hD2);
    check("shr_ser_out", bus.ser_out, 1'b0);
    bus.mode = 2'b00;
    tick();
    check("hold_q", bus.q, 8'hD2);

    // Auto-serialise left from 81, with mode/pdata/start noise during the run
    bus.mode  = 2'b11;
    bus.pdata = 8'h81;
    tick();
    check("load_81", bus.q, 8'h81);
    bus.mode     = 2'b10;
    bus.start    = 1'b1;
    bus.ser_in_l = 1'b0;
    ser_exp = 8'b1000_0001;
    qe      = 8'h81;
    check("auto_ser0", bus.ser_out, ser_exp[0]);
    tick();
    bus.mode  = 2'b11;
    bus.pdata = 8'hFF;
    bus.start = 1'b1;
    for (int k = 1; k < 8; k++) begin
      qe = {qe[6:0], 1'b0};
      check($sformatf("auto_q%0d", k),    bus.q,       qe);
      check($sformatf("auto_busy%0d", k), bus.busy,    1'b1);
      check($sformatf("auto_done%0d", k), bus.done,    1'b0);
      check($sformatf("auto_ser%0d", k),  bus.ser_out, ser_exp[k]);
      tick();
    end
    check("auto_end_q",    bus.q,    8'h00);
    check("auto_end_busy", bus.busy, 1'b0);
    check("auto_end_done", bus.done, 1'b1);
    tick();
    check("post_done_q",    bus.q,    8'h00);
    check("post_done_done", bus.done, 1'b0);
    check("post_done_busy", bus.busy, 1'b0);
    bus.mode  = 2'b00;
    bus.start = 1'b0;
    tick();

    // Clear aborts an auto run after the third shift
    bus.mode  = 2'b11;
    bus.pdata = 8'hFF;
    tick();
    bus.mode     = 2'b01;
    bus.start    = 1'b1;
    bus.ser_in_r = 1'b0;
    tick();
    bus.mode  = 2'b00;
    bus.start = 1'b0;
    tick();
    tick();
    check("abort_pre_q",    bus.q,    8'h1F);
    check("abort_pre_busy", bus.busy, 1'b1);
    #2 clear = 1'b1;
    #4;
    check("abort_q",    bus.q,    8'h00);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    clear = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("abort_no_done%0d", k), bus.done, 1'b0);
      check($sformatf("abort_idle%0d", k),    bus.busy, 1'b0);
    end
    check("abort_final_q", bus.q, 8'h00);

    // Start with mode=11 is just a load
    bus.mode  = 2'b11;
    bus.pdata = 8'h5A;
    bus.start = 1'b1;
    tick();
    check("start_ld_q",    bus.q,    8'h5A);
    check("start_ld_busy", bus.busy, 1'b0);
    check("start_ld_done", bus.done, 1'b0);
    bus.mode  = 2'b00;
    bus.start = 1'b0;
    tick();
    check("start_ld_q2",    bus.q,    8'h5A);
    check("start_ld_busy2", bus.busy, 1'b0);
    check("start_ld_done2", bus.done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
